// File: rtl/freq_meter_if.sv
// Measurement bus of the gated frequency/period meter.
// Ports: sig_in/start/cont from the requester, edge_cnt/period/valid/busy/ovf
// back from the meter. CW sets the width of the edge count and the period.
interface freq_meter_if #(
  parameter int CW = 16
);
  logic          sig_in;    // signal under measurement, asynchronous to clk
  logic          start;     // one-shot measurement request
  logic          cont;      // keep re-opening windows back to back
  logic [CW-1:0] edge_cnt;  // rising edges in the last completed window
  logic [CW-1:0] period;    // clk cycles between the last two rises
  logic          valid;     // one-cycle pulse when results update
  logic          busy;      // a window is open
  logic          ovf;       // last window saturated a counter

  // Requester side: drives the stimulus and control, reads the results.
  modport master (
    output sig_in, start, cont,
    input  edge_cnt, period, valid, busy, ovf
  );

  // Meter side.
  modport slave (
    input  sig_in, start, cont,
    output edge_cnt, period, valid, busy, ovf
  );
endinterface

// File: rtl/freq_meter.sv
// Gated frequency and period meter: counts rises of sig_in over GATE_CYCLES clk
// cycles and captures the spacing of the last two rises in the window.
// Latency: rise seen 2-3 clk after the sig_in edge; results + valid one clk after the last gate cycle.
// Ports: clk, rst (async active-low), bus (freq_meter_if.slave); no backpressure.
module freq_meter #(
  parameter int GATE_CYCLES = 1000,
  parameter int CW          = 16
) (
  input  logic         clk,
  input  logic         rst,
  freq_meter_if.slave  bus
);

  localparam int            GW   = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CW-1:0] MAX  = '1;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t        state;
  logic          s1, s2, s3;
  logic [GW-1:0] gate_cnt;
  logic [CW-1:0] edge_acc;
  logic [CW-1:0] ival;
  logic [CW-1:0] per_acc;
  logic          seen_first;
  logic          ovf_acc;

  logic [CW-1:0] edge_cnt_q;
  logic [CW-1:0] period_q;
  logic          valid_q;
  logic          busy_q;
  logic          ovf_q;

  // Two-flop synchronizer plus a history flop for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  logic          rise;
  logic          edge_sat;
  logic          ival_sat;
  logic          last;
  logic [CW-1:0] ival_inc;
  logic [CW-1:0] edge_nxt;
  logic [CW-1:0] ival_nxt;
  logic [CW-1:0] per_nxt;
  logic          ovf_nxt;

  // Next accumulator values for the current MEASURE cycle. They are also what
  // gets published on the last gate cycle, so that cycle's rise is included.
  always_comb begin
    rise     = s2 & ~s3;
    edge_sat = (edge_acc == MAX);
    ival_sat = (ival == MAX);
    last     = (gate_cnt == LAST);
    ival_inc = ival_sat ? MAX : ival + 1'b1;
    edge_nxt = edge_acc;
    ival_nxt = ival_inc;
    per_nxt  = per_acc;
    if (rise) begin
      edge_nxt = edge_sat ? MAX : edge_acc + 1'b1;
      ival_nxt = '0;
      if (seen_first) begin
        per_nxt = ival_inc;
      end
    end
    ovf_nxt = ovf_acc | ival_sat | (rise & edge_sat);
  end

  // Window FSM. Accumulators are held cleared while idle and cleared again on
  // the last gate cycle, so every window starts from zero whether it was
  // opened by start or chained by cont.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      gate_cnt   <= '0;
      edge_acc   <= '0;
      ival       <= '0;
      per_acc    <= '0;
      seen_first <= 1'b0;
      ovf_acc    <= 1'b0;
      edge_cnt_q <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          gate_cnt   <= '0;
          edge_acc   <= '0;
          ival       <= '0;
          per_acc    <= '0;
          seen_first <= 1'b0;
          ovf_acc    <= 1'b0;
          if (bus.start) begin
            state  <= MEASURE;
            busy_q <= 1'b1;
          end
        end
        MEASURE: begin
          if (last) begin
            edge_cnt_q <= edge_nxt;
            period_q   <= per_nxt;
            ovf_q      <= ovf_nxt;
            valid_q    <= 1'b1;
            gate_cnt   <= '0;
            edge_acc   <= '0;
            ival       <= '0;
            per_acc    <= '0;
            seen_first <= 1'b0;
            ovf_acc    <= 1'b0;
            if (!bus.cont) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
            edge_acc <= edge_nxt;
            ival     <= ival_nxt;
            per_acc  <= per_nxt;
            ovf_acc  <= ovf_nxt;
            if (rise) begin
              seen_first <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.edge_cnt = edge_cnt_q;
  assign bus.period   = period_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;
  assign bus.ovf      = ovf_q;

endmodule
